// File: rtl/if_id_buffer.sv
// Two-entry skid buffer between fetch and decode, with a valid/ready handshake on both sides.
// It also provides a synchronous flush for redirects and freezes intake once a HALT is accepted.
module if_id_buffer #(
    parameter logic [15:0] NOP_INSTR  = 16'h0800,
    parameter logic [15:0] HALT_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_in,
    input  logic [15:0] pc_plus_two_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus_two_out,
    output logic [1:0]  occupancy,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_halted;
    logic        w_halted_nxt;

    logic [15:0] r_main_instr;
    logic [15:0] r_main_pc;
    logic [15:0] r_main_pc2;
    logic [15:0] r_skid_instr;
    logic [15:0] r_skid_pc;
    logic [15:0] r_skid_pc2;

    logic        w_accept;
    logic        w_drain;
    logic        w_load_main_in;
    logic        w_load_main_skid;
    logic        w_load_skid;

    // Handshakes depend only on registered state, so there is no combinational path to either side.
    assign in_ready  = (r_state != ST_TWO) && !r_halted;
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;

    assign instr_out       = out_valid ? r_main_instr : NOP_INSTR;
    assign pc_out          = r_main_pc;
    assign pc_plus_two_out = r_main_pc2;
    assign halted          = r_halted;

    always_comb begin
        unique case (r_state)
            ST_ONE:  occupancy = 2'd1;
            ST_TWO:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path through it can infer a latch.
        w_state_nxt      = r_state;
        w_halted_nxt     = r_halted;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;

        if (flush) begin
            // A redirect discards everything, including any same-cycle accept or drain.
            w_state_nxt  = ST_EMPTY;
            w_halted_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_load_main_in = 1'b1;
                        w_state_nxt    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_TWO;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_drain) begin
                        w_load_main_skid = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase

            if (w_accept && (instr_in == HALT_INSTR)) begin
                w_halted_nxt = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // NOTE: the payload registers are reset as well, because pc_out must read zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_instr <= '0;
            r_main_pc    <= '0;
            r_main_pc2   <= '0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_skid_pc2   <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_instr <= instr_in;
                r_main_pc    <= pc_in;
                r_main_pc2   <= pc_plus_two_in;
            end else if (w_load_main_skid) begin
                r_main_instr <= r_skid_instr;
                r_main_pc    <= r_skid_pc;
                r_main_pc2   <= r_skid_pc2;
            end
            if (w_load_skid) begin
                r_skid_instr <= instr_in;
                r_skid_pc    <= pc_in;
                r_skid_pc2   <= pc_plus_two_in;
            end
        end
    end

endmodule
